ones_serializer: RTL and testbench

Inverse of the population counter: accepts a bit count over a valid/ready handshake and emits a WIDTH-bit serial frame holding exactly that many ones, thermometer-ordered (ones first). It also exposes the parallel thermometer mask. It sits on the producer side of serial links whose consumer reduces each frame back to a count with `count_ones`. A frame is produced from a count and reduced back to that count at the far end.

---
 rtl/ones_serializer.sv | 105 ++++++++++
 tb/tb_ones_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ones_serializer.sv
// Count-to-thermometer serializer: turns an accepted bit count into a WIDTH-bit
// serial frame with that many ones first, and exposes the matching parallel mask.
module ones_serializer #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   count_valid,
  output logic                   count_ready,
  input  logic [COUNT_WIDTH-1:0] count,
  output logic                   bit_valid,
  input  logic                   bit_ready,
  output logic                   bit_data,
  output logic                   bit_last,
  output logic [WIDTH-1:0]       mask,
  output logic                   busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [COUNT_WIDTH-1:0] MAX_CNT  = COUNT_WIDTH'(WIDTH);
  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(WIDTH - 1);

  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] idx_q;
  logic [COUNT_WIDTH-1:0] n_q;
  logic                   bit_valid_q;
  logic                   bit_data_q;
  logic                   bit_last_q;
  logic [WIDTH-1:0]       mask_q;
  logic                   busy_q;

  logic [COUNT_WIDTH-1:0] n_sat_d;
  logic [COUNT_WIDTH-1:0] idx_inc_d;

  function automatic logic [WIDTH-1:0] thermo(input logic [COUNT_WIDTH-1:0] n);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  // Counts above WIDTH are legal on the input and simply clamp to an all-ones frame.
  always_comb begin
    n_sat_d   = (count > MAX_CNT) ? MAX_CNT : count;
    idx_inc_d = idx_q + COUNT_WIDTH'(1);
  end

  assign count_ready = !reset && (state_q == IDLE);
  assign bit_valid   = bit_valid_q;
  assign bit_data    = bit_data_q;
  assign bit_last    = bit_last_q;
  assign mask        = mask_q;
  assign busy        = busy_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      n_q         <= '0;
      bit_valid_q <= 1'b0;
      bit_data_q  <= 1'b0;
      bit_last_q  <= 1'b0;
      mask_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_valid) begin
            state_q     <= STREAM;
            n_q         <= n_sat_d;
            mask_q      <= thermo(n_sat_d);
            idx_q       <= '0;
            bit_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            bit_data_q  <= (n_sat_d != '0);
            bit_last_q  <= 1'b0;
          end
        end
        STREAM: begin
          // Data/last for the following beat are precomputed so the outputs stay registered.
          if (bit_ready) begin
            if (bit_last_q) begin
              state_q     <= IDLE;
              idx_q       <= '0;
              bit_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              bit_data_q  <= 1'b0;
              bit_last_q  <= 1'b0;
            end else begin
              idx_q      <= idx_inc_d;
              bit_data_q <= (idx_inc_d < n_q);
              bit_last_q <= (idx_inc_d == LAST_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_serializer.sv
// Randomized self-checking bench for ones_serializer at WIDTH=8 (full protocol
// checks) and WIDTH=13 (frame-to-count round trip).
module tb_ones_serializer;

  logic       clock;
  logic       reset;
  logic       c_valid;
  logic       count_ready;
  logic [3:0] c_cnt;
  logic       bit_valid;
  logic       b_ready;
  logic       bit_data;
  logic       bit_last;
  logic [7:0] mask;
  logic       busy;

  logic        r13;
  logic        c13_valid;
  logic        c13_ready;
  logic [3:0]  c13_cnt;
  logic        b13_valid;
  logic        b13_ready;
  logic        b13_data;
  logic        b13_last;
  logic [12:0] mask13;
  logic        busy13;

  int vectors    = 0;
  int miscompare = 0;
  bit done13     = 0;

  ones_serializer #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .count_valid(c_valid), .count_ready(count_ready),
    .count(c_cnt), .bit_valid(bit_valid), .bit_ready(b_ready), .bit_data(bit_data),
    .bit_last(bit_last), .mask(mask), .busy(busy)
  );

  ones_serializer #(.WIDTH(13)) dut13 (
    .clock(clock), .reset(r13), .count_valid(c13_valid), .count_ready(c13_ready),
    .count(c13_cnt), .bit_valid(b13_valid), .bit_ready(b13_ready), .bit_data(b13_data),
    .bit_last(b13_last), .mask(mask13), .busy(busy13)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompare++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] thermo_ref(input int n);
    return (32'd1 << n) - 32'd1;
  endfunction

  // One WIDTH=8 frame from the current sample point; returns at the sample after the last beat.
  task automatic run_frame(input int cnt, input int stall_pct, input bit hold, input int next_cnt);
    int   n, beat, stalls, cyc, guard;
    logic pd, pl;
    bit   stalled;
    n = (cnt > 8) ? 8 : cnt;
    guard = 0;
    while (!count_ready && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    check_eq("rdy_wait", count_ready, 1);
    c_valid = 1'b1;
    c_cnt   = 4'(cnt);
    @(posedge clock); #1;
    c_valid = hold;
    if (hold) c_cnt = 4'(next_cnt);
    check_eq("first_vld", bit_valid, 1);
    check_eq("mask", mask, thermo_ref(n));
    beat = 0; stalls = 0; cyc = 0; stalled = 0; pd = 0; pl = 0;
    while (beat < 8 && cyc < 400) begin
      check_eq("vld_mid", bit_valid, 1);
      check_eq("busy_mid", busy, 1);
      check_eq("rdy_mid", count_ready, 0);
      if (stalled) begin
        check_eq("hold_data", bit_data, pd);
        check_eq("hold_last", bit_last, pl);
      end
      b_ready = ($urandom_range(99) >= stall_pct);
      if (b_ready) begin
        check_eq("data", bit_data, (beat < n));
        check_eq("last", bit_last, (beat == 7));
        beat++;
        stalled = 0;
      end else begin
        stalls++;
        stalled = 1;
        pd = bit_data;
        pl = bit_last;
      end
      cyc++;
      @(posedge clock); #1;
    end
    b_ready = 1'b0;
    check_eq("frame_len", cyc, 8 + stalls);
    check_eq("end_vld", bit_valid, 0);
    check_eq("end_rdy", count_ready, 1);
    check_eq("end_busy", busy, 0);
    check_eq("mask_hold", mask, thermo_ref(n));
  endtask

  initial begin
    int guard;
    reset = 1'b1; c_valid = 1'b0; c_cnt = '0; b_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_rdy", count_ready, 0);
    check_eq("rst_vld", bit_valid, 0);
    check_eq("rst_data", bit_data, 0);
    check_eq("rst_last", bit_last, 0);
    check_eq("rst_mask", mask, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_rdy", count_ready, 1);

    run_frame(3, 0, 1'b0, 0);
    run_frame(0, 0, 1'b1, 8);
    run_frame(8, 0, 1'b0, 0);
    run_frame(12, 0, 1'b0, 0);
    run_frame(5, 40, 1'b0, 0);

    // Reset after the 4th accepted beat of a count=6 frame.
    c_valid = 1'b1; c_cnt = 4'd6;
    @(posedge clock); #1;
    c_valid = 1'b0;
    b_ready = 1'b1;
    repeat (4) begin
      @(posedge clock); #1;
    end
    check_eq("pre_rst_vld", bit_valid, 1);
    reset = 1'b1;
    #1;
    check_eq("midrst_rdy", count_ready, 0);
    @(posedge clock); #1;
    check_eq("midrst_vld", bit_valid, 0);
    check_eq("midrst_mask", mask, 0);
    check_eq("midrst_busy", busy, 0);
    reset = 1'b0; b_ready = 1'b0;
    #1;
    check_eq("rel_rdy", count_ready, 1);
    run_frame(2, 0, 1'b0, 0);

    // Reset wins over a simultaneous count request.
    reset = 1'b1; c_valid = 1'b1; c_cnt = 4'd4;
    @(posedge clock); #1;
    reset = 1'b0; c_valid = 1'b0;
    #1;
    check_eq("rst_vs_cnt_vld", bit_valid, 0);
    check_eq("rst_vs_cnt_mask", mask, 0);

    for (int f = 0; f < 1000; f++) begin
      run_frame($urandom_range(15), $urandom_range(30), 1'b0, 0);
    end

    guard = 0;
    while (!done13 && guard < 60000) begin
      @(posedge clock);
      guard++;
    end
    check_eq("rt13_done", done13, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompare);
    $finish;
  end

  // WIDTH=13 round trip: reduce each frame back to a count and compare with the clamped request.
  initial begin
    int cnt, ones, beats, guard;
    bit seen_last;
    r13 = 1'b1; c13_valid = 1'b0; c13_cnt = '0; b13_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    r13 = 1'b0;
    for (int f = 0; f < 1000; f++) begin
      cnt = $urandom_range(15);
      guard = 0;
      while (!c13_ready && guard < 50) begin
        @(posedge clock); #1;
        guard++;
      end
      c13_valid = 1'b1;
      c13_cnt   = 4'(cnt);
      @(posedge clock); #1;
      c13_valid = 1'b0;
      ones = 0; beats = 0; guard = 0; seen_last = 0;
      while (!seen_last && guard < 400) begin
        b13_ready = ($urandom_range(99) >= 25);
        if (b13_ready && b13_valid) begin
          ones += int'(b13_data);
          beats++;
          seen_last = b13_last;
        end
        guard++;
        @(posedge clock); #1;
      end
      b13_ready = 1'b0;
      check_eq("rt13_ones", ones, (cnt > 13) ? 13 : cnt);
      check_eq("rt13_len", beats, 13);
      check_eq("rt13_mask", mask13, thermo_ref((cnt > 13) ? 13 : cnt));
    end
    done13 = 1'b1;
  end

endmodule
